// File: rtl/uart_tx.sv
// UART transmitter: LSB-first frames (start, DATA_BITS data, optional parity, STOP_BITS stop),
// one bit per baud_tick. Define UART_TX_PARITY_EN to insert the parity bit.
module uart_tx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_t;
  logic parity_bit;
`else
  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;
  logic parity_odd_unused;
  assign parity_odd_unused = 1'(PARITY_ODD);
`endif

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;

  // Frame sequencer; SYNC waits for a tick so the start bit spans a full bit time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_valid && tx_ready) begin
            shift    <= tx_data;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= SYNC;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
          end
        end
        SYNC: begin
          if (baud_tick) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            tx      <= shift[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
`endif
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            if (stop_cnt == LAST_STOP) begin
              state    <= IDLE;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
